card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer_if.sv | 23 ++
 rtl/card_dealer.sv | 136 +++++++++++++
 tb/tb_card_dealer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Bus between a card_dealer and whoever requests cards from it.
interface card_dealer_if;
    // shuffle_start/deal_req are one-cycle request pulses with no ready; a deal is
    // answered by card_valid one cycle later, and busy marks when deal_req is ignored.
    logic       shuffle_start;
    logic       deal_req;
    logic       card_valid;
    logic [3:0] card;
    logic [1:0] suit;
    logic [5:0] cards_left;
    logic       busy;
    logic       empty;

    modport master (
        output shuffle_start, deal_req,
        input  card_valid, card, suit, cards_left, busy, empty
    );

    modport slave (
        input  shuffle_start, deal_req,
        output card_valid, card, suit, cards_left, busy, empty
    );
endinterface

// File: rtl/card_dealer.sv
// 52-card dealer with LFSR-driven in-place shuffle.
// Define CARD_DEALER_SHUFFLE_EN to build the shuffle; otherwise the deck deals in index order.
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          reset,
    card_dealer_if.slave  bus,
    output logic [1:0]    state_dbg
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        RELOAD  = 2'd1,
        SHUFFLE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  deck [52];
    logic [5:0]  top;
    logic [15:0] lfsr;
    logic        deal_fire;
    logic        valid_r;
    logic [3:0]  card_r;
    logic [1:0]  suit_r;

    function automatic logic [1:0] suit_of(input logic [5:0] k);
        if (k >= 6'd39)      return 2'd3;
        else if (k >= 6'd26) return 2'd2;
        else if (k >= 6'd13) return 2'd1;
        else                 return 2'd0;
    endfunction

    function automatic logic [3:0] rank_of(input logic [5:0] k);
        logic [5:0] r;
        if (k >= 6'd39)      r = k - 6'd39;
        else if (k >= 6'd26) r = k - 6'd26;
        else if (k >= 6'd13) r = k - 6'd13;
        else                 r = k;
        return r[3:0] + 4'd1;
    endfunction

`ifdef CARD_DEALER_SHUFFLE_EN
    logic [5:0] idx_i;
    logic [5:0] cand_j;
    logic       swap_ok;

    assign cand_j  = lfsr[5:0];
    assign swap_ok = (state == SHUFFLE) && (cand_j <= idx_i);

    always_ff @(posedge clk) begin
        if (reset)                idx_i <= 6'd51;
        else if (state == RELOAD) idx_i <= 6'd51;
        else if (swap_ok)         idx_i <= idx_i - 6'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= READY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.shuffle_start) begin
            state_nxt = RELOAD;
        end else begin
            case (state)
`ifdef CARD_DEALER_SHUFFLE_EN
                RELOAD:  state_nxt = SHUFFLE;
                SHUFFLE: if (swap_ok && idx_i == 6'd1) state_nxt = READY;
`else
                RELOAD:  state_nxt = READY;
                SHUFFLE: state_nxt = READY;
`endif
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        bus.busy  = (state != READY);
        state_dbg = state;
    end

    assign deal_fire = (state == READY) && bus.deal_req && !bus.shuffle_start
                       && (top != 6'd52);

    // Galois form: shift right, fold the mask in when a one falls out.
    always_ff @(posedge clk) begin
        if (reset)        lfsr <= SEED_EFF;
        else if (lfsr[0]) lfsr <= (lfsr >> 1) ^ 16'hB400;
        else              lfsr <= lfsr >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset || state == RELOAD) begin
            for (int k = 0; k < 52; k++) deck[k] <= 6'(k);
        end
`ifdef CARD_DEALER_SHUFFLE_EN
        else if (swap_ok) begin
            deck[idx_i]  <= deck[cand_j];
            deck[cand_j] <= deck[idx_i];
        end
`endif
    end

    // Clearing on the accepting edge makes card/cards_left already reset while in RELOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            top     <= 6'd0;
            card_r  <= 4'd0;
            suit_r  <= 2'd0;
        end else begin
            valid_r <= deal_fire;
            if (bus.shuffle_start || state == RELOAD) begin
                top    <= 6'd0;
                card_r <= 4'd0;
                suit_r <= 2'd0;
            end else if (deal_fire) begin
                top    <= top + 6'd1;
                card_r <= rank_of(deck[top]);
                suit_r <= suit_of(deck[top]);
            end
        end
    end

    assign bus.card_valid = valid_r;
    assign bus.card       = card_r;
    assign bus.suit       = suit_r;
    assign bus.cards_left = 6'd52 - top;
    assign bus.empty      = (top == 6'd52);
endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: ordered dealing, empty handling, reload/shuffle and reset.
module tb_card_dealer;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    card_dealer_if bus_if();

    card_dealer dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_left;
    logic [5:0] exp_q [$];
    logic [5:0] seq_cur [52];
    logic [5:0] seq_a [52];
    logic [5:0] seq_b [52];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.shuffle_start = 1'b0;
        bus_if.deal_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        exp_left = 52;
        exp_q.delete();
    endtask

    task automatic take_card(input string tag);
        logic [5:0] k;
        k = exp_q.pop_front();
        exp_left--;
        check_eq({tag, "_valid"}, bus_if.card_valid, 1);
        check_eq({tag, "_card"}, bus_if.card, (k % 13) + 1);
        check_eq({tag, "_suit"}, bus_if.suit, k / 13);
        check_eq({tag, "_left"}, bus_if.cards_left, exp_left);
        check_eq({tag, "_empty"}, bus_if.empty, exp_left == 0);
    endtask

    task automatic deal_single(input string tag);
        bus_if.deal_req = 1'b1;
        step();
        bus_if.deal_req = 1'b0;
        take_card(tag);
        step();
        check_eq({tag, "_drop"}, bus_if.card_valid, 0);
    endtask

    task automatic deal_burst(input int n, input string tag);
        bus_if.deal_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == n - 1) bus_if.deal_req = 1'b0;
            take_card(tag);
        end
        step();
        check_eq({tag, "_drop"}, bus_if.card_valid, 0);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (bus_if.busy && cyc < 5000) begin
            step();
            cyc++;
        end
        check_eq({tag, "_busy_timeout"}, bus_if.busy, 0);
    endtask

    task automatic run_shuffle(input string tag);
        logic [51:0] seen;
        logic [5:0]  idx;
        do_reset();
        bus_if.shuffle_start = 1'b1;
        step();
        bus_if.shuffle_start = 1'b0;
        check_eq({tag, "_reload_busy"}, bus_if.busy, 1);
        check_eq({tag, "_reload_state"}, state_dbg, 1);
        check_eq({tag, "_reload_card"}, bus_if.card, 0);
        check_eq({tag, "_reload_left"}, bus_if.cards_left, 52);
        bus_if.deal_req = 1'b1;
        step();
        bus_if.deal_req = 1'b0;
        check_eq({tag, "_busy_deal_valid"}, bus_if.card_valid, 0);
        check_eq({tag, "_busy_deal_left"}, bus_if.cards_left, 52);
        wait_idle(tag);
        seen = '0;
        for (int k = 0; k < 52; k++) begin
            bus_if.deal_req = 1'b1;
            step();
            bus_if.deal_req = 1'b0;
            check_eq({tag, "_valid"}, bus_if.card_valid, 1);
            check_eq({tag, "_rank_range"}, (bus_if.card >= 1) && (bus_if.card <= 13), 1);
            idx = (bus_if.card >= 1) ? 6'(bus_if.suit * 13 + bus_if.card - 1) : 6'd0;
            check_eq({tag, "_unique"}, seen[idx], 0);
            seen[idx] = 1'b1;
            seq_cur[k] = idx;
`ifndef CARD_DEALER_SHUFFLE_EN
            check_eq({tag, "_ordered"}, idx, k);
`endif
            step();
        end
        check_eq({tag, "_all_seen"}, seen, {52{1'b1}});
        check_eq({tag, "_empty"}, bus_if.empty, 1);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.shuffle_start = 1'b0;
        bus_if.deal_req = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_valid", bus_if.card_valid, 0);
        check_eq("rst_card", bus_if.card, 0);
        check_eq("rst_suit", bus_if.suit, 0);
        check_eq("rst_left", bus_if.cards_left, 52);
        check_eq("rst_busy", bus_if.busy, 0);
        check_eq("rst_empty", bus_if.empty, 0);
        check_eq("rst_state", state_dbg, 0);

        // Three single deals, then the rest back-to-back
        for (int k = 0; k < 52; k++) exp_q.push_back(6'(k));
        deal_single("deal0");
        deal_single("deal1");
        deal_single("deal2");
        check_eq("after3_left", bus_if.cards_left, 49);
        check_eq("after3_card", bus_if.card, 3);
        deal_burst(49, "burst");

        // 53rd request on an empty deck
        bus_if.deal_req = 1'b1;
        step();
        bus_if.deal_req = 1'b0;
        check_eq("empty_valid", bus_if.card_valid, 0);
        check_eq("empty_card", bus_if.card, 13);
        check_eq("empty_suit", bus_if.suit, 3);
        check_eq("empty_left", bus_if.cards_left, 0);
        check_eq("empty_flag", bus_if.empty, 1);

        // Reload + deal, twice from the same reset timing
        run_shuffle("shufA");
        seq_a = seq_cur;
        run_shuffle("shufB");
        seq_b = seq_cur;
        for (int k = 0; k < 52; k++) check_eq("repeat_seq", seq_b[k], seq_a[k]);

        // shuffle_start and deal_req together after 10 deals
        do_reset();
        for (int k = 0; k < 10; k++) exp_q.push_back(6'(k));
        deal_burst(10, "pre10");
        bus_if.shuffle_start = 1'b1;
        bus_if.deal_req = 1'b1;
        step();
        bus_if.shuffle_start = 1'b0;
        bus_if.deal_req = 1'b0;
        check_eq("collide_valid", bus_if.card_valid, 0);
        check_eq("collide_left", bus_if.cards_left, 52);
        check_eq("collide_card", bus_if.card, 0);
        check_eq("collide_suit", bus_if.suit, 0);
        check_eq("collide_state", state_dbg, 1);
        wait_idle("collide");

        // Reset while busy
        do_reset();
        bus_if.shuffle_start = 1'b1;
        step();
        bus_if.shuffle_start = 1'b0;
`ifdef CARD_DEALER_SHUFFLE_EN
        step();
        step();
`endif
        check_eq("midshuf_busy", bus_if.busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("midrst_busy", bus_if.busy, 0);
        check_eq("midrst_left", bus_if.cards_left, 52);
        check_eq("midrst_state", state_dbg, 0);
        exp_left = 52;
        exp_q.delete();
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd1);
        deal_single("midrst_d0");
        deal_single("midrst_d1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
